// File: rtl/i2c_pkg.sv
// Shared constants for the two-requester I2C master arbiter.
// Holds FSM state encoding, default timeout and bus widths.
package i2c_pkg;

    localparam int TIMEOUT_CYC_DEF = 4000;
    localparam int ADDR_W_DEF      = 7;
    localparam int DATA_W          = 8;
    localparam int N_REQ           = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/i2c_rr_arb2.sv
// Combinational 2-way round-robin selector.
// Ports: valid[1:0] requests, last = index granted last, grant one-hot.
module i2c_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        // Contention: the side not served last time wins.
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C master between two requesters, one transaction at a time.
// Ports: req_* requester side, rsp_* completion side, m_* master side, busy.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [1:0]          req_rw,
    input  logic [15:0]         req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [7:0]          rsp_rdata,
    output logic                rsp_timeout,
    output logic                busy,
    output logic                m_start,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_rw,
    output logic [7:0]          m_data_send,
    input  logic                m_done,
    input  logic [7:0]          m_data_recv,
    input  logic                m_data_recv_done
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              to_q, to_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q;
    logic              done_rise;
    logic [1:0]        gnt;
    logic              in_resp;

    i2c_rr_arb2 u_arb (
        .valid (req_valid),
        .last  (last_q),
        .grant (gnt)
    );

    assign done_rise = m_done & ~done_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    gnt_d   = gnt[1];
                    addr_d  = gnt[1] ? req_addr[2*ADDR_W-1:ADDR_W]
                                     : req_addr[ADDR_W-1:0];
                    rw_d    = gnt[1] ? req_rw[1] : req_rw[0];
                    wdata_d = gnt[1] ? req_wdata[15:8] : req_wdata[7:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rdata_d = 8'h00;
                cnt_d   = '0;
                to_d    = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_data_recv_done) begin
                    rdata_d = m_data_recv;
                end
                // A done edge beats the terminal count.
                if (done_rise) begin
                    to_d    = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    to_d    = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            done_q  <= m_done;
        end
    end

    // Outputs are forced low while rst is high, not only after the edge.
    assign in_resp     = !rst && (state_q == ST_RESP);
    assign req_ready   = (!rst && state_q == ST_IDLE) ? gnt : 2'b00;
    assign busy        = !rst && (state_q != ST_IDLE);
    assign m_start     = !rst && (state_q == ST_ISSUE);
    assign rsp_valid   = in_resp ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata   = (in_resp && rw_q) ? rdata_q : 8'h00;
    assign rsp_timeout = in_resp && to_q;
    assign m_addr      = rst ? '0 : addr_q;
    assign m_rw        = !rst && rw_q;
    assign m_data_send = rst ? 8'h00 : wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: two instances (default and 16-cycle timeout)
// share stimulus and are checked against a transaction-level model.
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [13:0] req_addr;
    logic [1:0]  req_rw;
    logic [15:0] req_wdata;
    logic        m_done;
    logic [7:0]  m_data_recv;
    logic        m_data_recv_done;

    logic [1:0] req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
    logic [7:0] rsp_rdata_a, rsp_rdata_b, m_data_send_a, m_data_send_b;
    logic       rsp_timeout_a, busy_a, m_start_a, m_rw_a;
    logic       rsp_timeout_b, busy_b, m_start_b, m_rw_b;
    logic [6:0] m_addr_a, m_addr_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    i2c_arbiter dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_a),
        .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
        .rsp_timeout(rsp_timeout_a), .busy(busy_a),
        .m_start(m_start_a), .m_addr(m_addr_a), .m_rw(m_rw_a),
        .m_data_send(m_data_send_a), .m_done(m_done),
        .m_data_recv(m_data_recv), .m_data_recv_done(m_data_recv_done)
    );

    i2c_arbiter #(.TIMEOUT_CYC(16)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .rsp_timeout(rsp_timeout_b), .busy(busy_b),
        .m_start(m_start_b), .m_addr(m_addr_b), .m_rw(m_rw_b),
        .m_data_send(m_data_send_b), .m_done(m_done),
        .m_data_recv(m_data_recv), .m_data_recv_done(m_data_recv_done)
    );

    // Model: a transaction is stamped with its accept cycle; the
    // response cycle is fixed once a done edge or timeout is seen.
    typedef struct {
        bit       act;
        int       acc;
        int       rsp;
        bit       own;
        bit       ptr;
        bit [6:0] ad;
        bit       rw;
        bit [7:0] wd;
        bit [7:0] rd;
        bit       to;
        bit       pd;
    } ms_t;

    ms_t ma, mb;

    function automatic logic [1:0] pick(logic [1:0] v, bit ptr);
        if (v == 2'b11) return 2'b01 << (!ptr);
        return v;
    endfunction

    function automatic ms_t nxt(ms_t m, int tc, int c);
        ms_t r;
        r = m;
        if (rst) begin
            r = '{act: 0, acc: 0, rsp: -1, own: 0, ptr: 1, ad: 0,
                  rw: 0, wd: 0, rd: 0, to: 0, pd: 0};
            return r;
        end
        if (!r.act) begin
            if (req_valid != 2'b00) begin
                r.own = (pick(req_valid, r.ptr) == 2'b10);
                r.ad  = r.own ? req_addr[13:7] : req_addr[6:0];
                r.rw  = req_rw[r.own];
                r.wd  = r.own ? req_wdata[15:8] : req_wdata[7:0];
                r.act = 1;
                r.acc = c;
                r.rsp = -1;
                r.rd  = 0;
                r.to  = 0;
            end
        end else if (r.rsp == c) begin
            r.act = 0;
            r.ptr = r.own;
        end else if (r.rsp < 0 && c >= r.acc + 2) begin
            if (m_data_recv_done) r.rd = m_data_recv;
            if (m_done && !r.pd) begin
                r.rsp = c + 1;
                r.to  = 0;
            end else if (c - r.acc - 2 == tc - 1) begin
                r.rsp = c + 1;
                r.to  = 1;
            end
        end
        r.pd = m_done;
        return r;
    endfunction

    function automatic logic [30:0] expect_out(ms_t m, int c);
        logic [1:0] rdy, rv;
        logic [7:0] rd;
        logic       now;
        if (rst) return '0;
        rdy = m.act ? 2'b00 : pick(req_valid, m.ptr);
        now = m.act && (m.rsp == c);
        rv  = now ? (2'b01 << m.own) : 2'b00;
        rd  = (now && m.rw) ? m.rd : 8'h00;
        return {rdy, rv, rd, now && m.to, m.act,
                m.act && (c == m.acc + 1), m.ad, m.rw, m.wd};
    endfunction

    always @(posedge clk) begin
        ma = nxt(ma, 4000, cyc);
        mb = nxt(mb, 16, cyc);
        cyc++;
    end

    always @(negedge clk) begin
        logic [30:0] ea, eb, aa, ab;
        ea = expect_out(ma, cyc);
        eb = expect_out(mb, cyc);
        aa = {req_ready_a, rsp_valid_a, rsp_rdata_a, rsp_timeout_a,
              busy_a, m_start_a, m_addr_a, m_rw_a, m_data_send_a};
        ab = {req_ready_b, rsp_valid_b, rsp_rdata_b, rsp_timeout_b,
              busy_b, m_start_b, m_addr_b, m_rw_b, m_data_send_b};
        n_cmp += 2;
        if (aa !== ea) begin
            n_bad++;
            $display("FAIL model_a cyc=%0d got %h want %h", cyc, aa, ea);
        end
        if (ab !== eb) begin
            n_bad++;
            $display("FAIL model_b cyc=%0d got %h want %h", cyc, ab, eb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [1:0] ord [4];
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_rw = '0;
        req_wdata = '0;
        m_done = 1'b0;
        m_data_recv = '0;
        m_data_recv_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_ready", int'(req_ready_a), 0);
        chk("reset_addr", int'(m_addr_a), 0);

        // Single write from requester 0, done 40 cycles after m_start.
        tick();
        req_valid = 2'b01;
        req_addr[6:0] = 7'h65;
        req_wdata[7:0] = 8'h63;
        #1;
        chk("wr_ready", int'(req_ready_a), 1);
        tick();
        req_valid = 2'b00;
        chk("wr_start", int'(m_start_a), 1);
        chk("wr_addr", int'(m_addr_a), 'h65);
        repeat (40) tick();
        m_done = 1'b1;
        tick();
        chk("wr_rsp", int'(rsp_valid_a), 1);
        chk("wr_rdata", int'(rsp_rdata_a), 0);
        chk("wr_to", int'(rsp_timeout_a), 0);
        chk("wr_ds", int'(m_data_send_a), 'h63);
        tick();
        chk("wr_idle", int'(busy_a), 0);
        m_done = 1'b0;

        // Single read from requester 1 with captured byte.
        tick();
        req_valid = 2'b10;
        req_addr[13:7] = 7'h65;
        req_rw = 2'b10;
        #1;
        chk("rd_ready", int'(req_ready_a), 2);
        tick();
        req_valid = 2'b00;
        repeat (4) tick();
        m_data_recv = 8'hE3;
        m_data_recv_done = 1'b1;
        tick();
        m_data_recv_done = 1'b0;
        m_data_recv = 8'h5A;
        repeat (2) tick();
        m_done = 1'b1;
        tick();
        chk("rd_rsp", int'(rsp_valid_a), 2);
        chk("rd_rdata", int'(rsp_rdata_a), 'hE3);
        chk("rd_rdata_b", int'(rsp_rdata_b), 'hE3);
        tick();
        m_done = 1'b0;

        // Timeout on the 16-cycle instance, m_done low.
        tick();
        req_valid = 2'b01;
        req_addr[6:0] = 7'h2A;
        req_rw = 2'b00;
        req_wdata[7:0] = 8'hC3;
        tick();
        req_valid = 2'b00;
        tick();
        k = 0;
        while (rsp_valid_b == 2'b00 && k < 40) begin
            tick();
            k++;
        end
        chk("to_latency", k, 16);
        chk("to_flag", int'(rsp_timeout_b), 1);
        chk("to_rsp", int'(rsp_valid_b), 1);
        tick();
        chk("to_idle_b", int'(busy_b), 0);
        chk("to_busy_a", int'(busy_a), 1);
        repeat (5) tick();
        m_done = 1'b1;
        tick();
        chk("to_a_done", int'(rsp_valid_a), 1);
        chk("to_a_flag", int'(rsp_timeout_a), 0);
        tick();
        m_done = 1'b0;

        // Done edge on the terminal-count cycle resolves as done.
        tick();
        req_valid = 2'b10;
        req_rw = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        repeat (15) tick();
        m_done = 1'b1;
        tick();
        chk("term_rsp", int'(rsp_valid_b), 2);
        chk("term_to", int'(rsp_timeout_b), 0);
        chk("term_rdata", int'(rsp_rdata_b), 0);
        tick();
        m_done = 1'b0;

        // Reset while waiting, then continuous contention.
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_rsp", int'(rsp_valid_a), 0);
        chk("rst_addr", int'(m_addr_a), 0);
        chk("rst_rw", int'(m_rw_a), 0);
        chk("rst_ds", int'(m_data_send_a), 0);
        req_valid = 2'b11;
        req_addr = {7'h11, 7'h22};
        req_rw = 2'b00;
        req_wdata = 16'hB4A5;
        #1;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (req_ready_a == 2'b00 && k < 50) begin
                tick();
                k++;
            end
            chk("grant_wait", int'(k < 50), 1);
            ord[i] = req_ready_a;
            tick();
            repeat (3) tick();
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
        end
        chk("order0", int'(ord[0]), 1);
        chk("order1", int'(ord[1]), 2);
        chk("order2", int'(ord[2]), 1);
        chk("order3", int'(ord[3]), 2);
        repeat (3) tick();
        req_valid = 2'b00;
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 4000, clk cycles allowed in WAIT before a transaction is abandoned.
REQ-002 SHALL have parameter ADDR_W, default 7, I2C slave address width.
REQ-003 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; one clock; all logic on rising edge.
- rst  in  1  reset is synchronous and active-high.
- req_valid  in  2  per-requester transaction request; payload held stable until req_ready.
- req_ready  out  2  one-cycle grant/accept pulse, at most one bit set.
- req_addr  in  2*ADDR_W  packed slave addresses; requester i at bits [i*7+6:i*7].
- req_rw  in  2  per-requester direction: 1 read, 0 write.
- req_wdata  in  16  packed write bytes; requester i at [i*8+7:i*8].
- rsp_valid  out  2  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read byte; valid with rsp_valid.
- rsp_timeout  out  1  1 = transaction abandoned by timeout; valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- m_start  out  1  one-cycle start pulse to the I2C master.
- m_addr  out  ADDR_W  slave address to the master.
- m_rw  out  1  direction to the master.
- m_data_send  out  8  write byte to the master.
- m_done  in  1  master completion level; a rising edge marks the end of a transaction.
- m_data_recv  in  8  master read byte.
- m_data_recv_done  in  1  master read-byte-valid pulse.

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one transaction at a time.
REQ-005 IDLE: if any req_valid, SHALL select winner g by round-robin, pulse req_ready[g], latch addr/rw/wdata into holding registers and go to ISSUE in the same cycle.
REQ-006 Round-robin rules:
- both valid: the requester not granted last wins;
- one valid: it wins regardless of the pointer;
- the pointer updates only in RESP.
REQ-007 ISSUE SHALL assert m_start for exactly one cycle, then enter WAIT with the timeout counter cleared.
REQ-008 m_addr/m_rw/m_data_send SHALL drive the holding registers, stable from ISSUE through RESP.
REQ-009 WAIT behaviour:
- m_data_recv_done=1: capture m_data_recv into the read register;
- m_done rising edge (registered previous-value compare): go to RESP, timeout=0;
- counter reaching TIMEOUT_CYC-1: go to RESP, timeout=1.
REQ-010 A m_done edge SHALL be acted on only in WAIT; edges in other states are ignored.
REQ-011 Simultaneous m_done edge and timeout terminal count SHALL resolve as done (rsp_timeout=0).
REQ-012 Simultaneous m_data_recv_done and m_done edge SHALL capture the data and complete in that same cycle.
REQ-013 RESP SHALL do the following for one cycle:
- pulse rsp_valid[g];
- drive rsp_rdata from the read register (0x00 for writes or when no byte was captured);
- drive rsp_timeout;
- set the pointer to g;
- return to IDLE.
REQ-014 Latency SHALL be: accept cycle N, m_start at N+1, rsp_valid 1 cycle after the m_done edge is sampled; the next accept is earliest 1 cycle after RESP.
REQ-015 Deassertion of req_valid before req_ready SHALL withdraw the request with no side effects.
REQ-016 The read register SHALL clear to 0x00 in ISSUE.

Reset
REQ-017 rst=1 SHALL force IDLE and clear every output to 0:
- req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy;
- m_start, m_addr, m_rw, m_data_send.
REQ-018 Reset SHALL also set the pointer to favour requester 0 and clear the counter, the holding registers and the m_done edge register.
REQ-019 Reset mid-transaction SHALL abandon it silently (no rsp_valid); resetting the I2C master is the system's responsibility.

Structure
REQ-020 Shared package i2c_pkg SHALL hold the FSM state encoding, the TIMEOUT_CYC default and the address/data width constants.
REQ-021 The 2-way round-robin selector SHALL be sub-module i2c_rr_arb2 (inputs: valid[1:0], last; output: one-hot grant), purely combinational.

Verification
REQ-022 Single write: req0 addr=0x65, rw=0, wdata=0x63; m_done rises 40 cycles after m_start -> rsp_valid[0] at edge+1, rsp_rdata=0x00, rsp_timeout=0, m_data_send=0x63 throughout.
REQ-023 Single read: req1 addr=0x65, rw=1; m_data_recv_done with 0xE3, then m_done edge -> rsp_valid[1], rsp_rdata=0xE3.
REQ-024 Contention: both valid continuously after reset -> grant order 0,1,0,1; each m_start exactly one cycle; never two req_ready bits set.
REQ-025 Timeout: TIMEOUT_CYC=16, m_done held low -> rsp_valid 16 cycles after WAIT entry with rsp_timeout=1, then IDLE and busy=0.
REQ-026 Edge cases:
- m_done edge on the terminal-count cycle -> rsp_timeout=0;
- rst asserted in WAIT -> next cycle all outputs 0, no rsp_valid, next grant goes to req0.
